// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // Widest arbiter this helper serves, and the index width that goes with it.
  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  // Converts a one-hot (or all-zero) vector to its bit index.
  // An all-zero vector maps to 0.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the write-back requesters and the register-file write port.
//
// Handshake: requester i transfers in a cycle when req_valid[i] && req_ready[i]
// at the rising edge. While req_valid[i]=1 and not granted, the requester holds
// req_reg/req_data stable. req_ready never depends on req_reg/req_data. The
// rf_write_* side has no back-pressure: the register file accepts every cycle.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                          stall;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_reg;
  logic [NUM_REQ*XLEN-1:0]       req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rf_write_enable;
  logic [REG_ADDR_W-1:0]         rf_write_reg;
  logic [XLEN-1:0]               rf_write_data;
  logic [IDX_W-1:0]              grant_id;

  // Requester / environment side.
  modport master (
    output stall, req_valid, req_reg, req_data,
    input  req_ready, rf_write_enable, rf_write_reg, rf_write_data, grant_id
  );

  // Arbiter side.
  modport slave (
    input  stall, req_valid, req_reg, req_data,
    output req_ready, rf_write_enable, rf_write_reg, rf_write_data, grant_id
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Generic round-robin arbiter: one-hot grant plus index, owning its priority
// pointer. Search starts at ptr and wraps; the pointer moves past each winner.
module rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N-1:0]                         req,
  input  logic                                 en,
  output logic [N-1:0]                         grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          hit;

  // (base + k) mod N, for k in 0..N-1 and base < N.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // First valid requester at or after ptr wins; nothing is granted when en=0.
  always_comb begin
    grant = '0;
    hit   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = wrap_idx(ptr, k);
      if (en && !hit && req[cand]) begin
        grant[cand] = 1'b1;
        hit         = 1'b1;
      end
    end
  end

  assign grant_idx = IW'(onehot_to_idx(MAX_REQ'(grant)));

  // Priority pointer: moves to the slot after the winner, holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= wrap_idx(grant_idx, 1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between NUM_REQ write-back sources.
// Round-robin grant, payload mux by grant index, one registered output stage.
// Writes to x0 are granted and consumed but never raise rf_write_enable.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = regfile_wb_arbiter_pkg::XLEN,
  parameter int REG_ADDR_W = regfile_wb_arbiter_pkg::REG_ADDR_W
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                  en;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_grant;
  logic [REG_ADDR_W-1:0] reg_arr  [NUM_REQ];
  logic [XLEN-1:0]       data_arr [NUM_REQ];
  logic [REG_ADDR_W-1:0] sel_reg;
  logic [XLEN-1:0]       sel_data;

  // Reset also masks grants so req_ready is zero while rst_n is low.
  assign en = rst_n & ~bus.stall;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .en        (en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;
  assign any_grant     = |grant;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reg_arr[i]  = bus.req_reg[i*REG_ADDR_W +: REG_ADDR_W];
    assign data_arr[i] = bus.req_data[i*XLEN +: XLEN];
  end

  assign sel_reg  = reg_arr[grant_idx];
  assign sel_data = data_arr[grant_idx];

  // Output stage: capture the winner; enable drops for idle slots and x0 writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rf_write_enable <= 1'b0;
      bus.rf_write_reg    <= '0;
      bus.rf_write_data   <= '0;
      bus.grant_id        <= '0;
    end else if (any_grant) begin
      bus.rf_write_enable <= (sel_reg != REG_ADDR_W'(ZERO_REG));
      bus.rf_write_reg    <= sel_reg;
      bus.rf_write_data   <= sel_data;
      bus.grant_id        <= grant_idx;
    end else begin
      bus.rf_write_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with an output scoreboard.
module tb_regfile_wb_arbiter;

  localparam int W = 40; // {we, reg[4:0], data[31:0], grant_id[1:0]}

  localparam logic [31:0] DA = 32'hA000_0001;
  localparam logic [31:0] DB = 32'hB000_0002;
  localparam logic [31:0] DC = 32'hC000_0003;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [31:0]  rf_model [32];

  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_got;
  string        mon_nm;

  regfile_wb_arbiter_if #(.NUM_REQ(3), .XLEN(32), .REG_ADDR_W(5)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pk(input logic we, input logic [4:0] r,
                                      input logic [31:0] d, input logic [1:0] g);
    return {we, r, d, g};
  endfunction

  // Driver: apply one cycle of stimulus at the falling edge, check the
  // combinational grant, and queue the output expected after the next edge.
  task automatic drive(input logic rn, input logic st, input logic [2:0] v,
                       input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0,
                       input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                       input logic [2:0] exp_rdy, input logic [W-1:0] exp_out,
                       input string name);
    @(negedge clk);
    rst_n         = rn;
    bus.stall     = st;
    bus.req_valid = v;
    bus.req_reg   = {r2, r1, r0};
    bus.req_data  = {d2, d1, d0};
    #1;
    checks++;
    if (bus.req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s req_ready: got %b want %b", name, bus.req_ready, exp_rdy);
    end
    exp_q.push_back(exp_out);
    name_q.push_back(name);
  endtask

  // Monitor: compare the output stage after each rising edge that has an expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_got = {bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data, bus.grant_id};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL %s out: got we=%b reg=%0d data=%h gid=%0d want we=%b reg=%0d data=%h gid=%0d",
                 mon_nm, mon_got[39], mon_got[38:34], mon_got[33:2], mon_got[1:0],
                 mon_exp[39], mon_exp[38:34], mon_exp[33:2], mon_exp[1:0]);
      end
      if (bus.rf_write_enable === 1'b1) rf_model[bus.rf_write_reg] = bus.rf_write_data;
    end
  end

  // Directed sequence.
  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.stall     = 1'b0;
    bus.req_valid = '0;
    bus.req_reg   = '0;
    bus.req_data  = '0;
    for (int i = 0; i < 32; i++) rf_model[i] = '0;

    // Reset with every requester valid.
    drive(0, 0, 3'b111, 5'd3, 5'd2, 5'd1, DC, DB, DA, 3'b000, pk(0, 0, 0, 0), "reset0");
    drive(0, 0, 3'b111, 5'd3, 5'd2, 5'd1, DC, DB, DA, 3'b000, pk(0, 0, 0, 0), "reset1");

    // Round-robin over three always-valid requesters.
    drive(1, 0, 3'b111, 5'd3, 5'd2, 5'd1, DC, DB, DA, 3'b001, pk(1, 1, DA, 0), "rr0");
    drive(1, 0, 3'b111, 5'd3, 5'd2, 5'd1, DC, DB, DA, 3'b010, pk(1, 2, DB, 1), "rr1");
    drive(1, 0, 3'b111, 5'd3, 5'd2, 5'd1, DC, DB, DA, 3'b100, pk(1, 3, DC, 2), "rr2");
    drive(1, 0, 3'b111, 5'd3, 5'd2, 5'd1, DC, DB, DA, 3'b001, pk(1, 1, DA, 0), "rr3");
    drive(1, 0, 3'b111, 5'd3, 5'd2, 5'd1, DC, DB, DA, 3'b010, pk(1, 2, DB, 1), "rr4");
    drive(1, 0, 3'b111, 5'd3, 5'd2, 5'd1, DC, DB, DA, 3'b100, pk(1, 3, DC, 2), "rr5");

    // x0 write: granted, not written; pointer then sits at 1.
    drive(1, 0, 3'b001, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'hDEADBEEF,
          3'b001, pk(0, 0, 32'hDEADBEEF, 0), "x0_drop");
    drive(1, 0, 3'b011, 5'd0, 5'd4, 5'd0, 32'd0, 32'h44, 32'd0,
          3'b010, pk(1, 4, 32'h44, 1), "ptr_after_x0");

    // Same target from req0 and req2 with the pointer at 2.
    drive(1, 0, 3'b101, 5'd7, 5'd0, 5'd7, 32'd22, 32'd0, 32'd11,
          3'b100, pk(1, 7, 32'd22, 2), "same_tgt_first");
    drive(1, 0, 3'b001, 5'd7, 5'd0, 5'd7, 32'd22, 32'd0, 32'd11,
          3'b001, pk(1, 7, 32'd11, 0), "same_tgt_second");

    // Stall: nothing granted, outputs hold, pointer holds at 1.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 3'b011, 5'd0, 5'd5, 5'd7, 32'd0, 32'h55, 32'd11,
            3'b000, pk(0, 7, 32'd11, 0), "stall");
    end
    drive(1, 0, 3'b011, 5'd0, 5'd5, 5'd7, 32'd0, 32'h55, 32'd11,
          3'b010, pk(1, 5, 32'h55, 1), "stall_release");
    drive(1, 0, 3'b011, 5'd0, 5'd5, 5'd6, 32'd0, 32'h55, 32'h66,
          3'b001, pk(1, 6, 32'h66, 0), "wrap_after_release");

    // Reset in the cycle after a grant; pointer must restart at 0.
    drive(1, 0, 3'b010, 5'd0, 5'd9, 5'd0, 32'd0, 32'h99, 32'd0,
          3'b010, pk(1, 9, 32'h99, 1), "grant_r9");
    drive(0, 0, 3'b010, 5'd0, 5'd9, 5'd0, 32'd0, 32'h99, 32'd0,
          3'b000, pk(0, 0, 32'd0, 0), "reset_mid");
    drive(1, 0, 3'b111, 5'd3, 5'd9, 5'd6, DC, 32'h99, 32'h66,
          3'b001, pk(1, 6, 32'h66, 0), "ptr_after_reset");
    drive(1, 0, 3'b000, 5'd3, 5'd9, 5'd6, DC, 32'h99, 32'h66,
          3'b000, pk(0, 6, 32'h66, 0), "idle");

    @(posedge clk);
    @(posedge clk);
    #2;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    checks++;
    if (rf_model[7] !== 32'd11) begin
      errors++;
      $display("FAIL x7_final: got %0d want 11", rf_model[7]);
    end
    checks++;
    if (rf_model[0] !== 32'd0) begin
      errors++;
      $display("FAIL x0_final: got %h want 0", rf_model[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
